// File: rtl/aes_package.sv
// Shared types, round-count constants and key-length decoding
// for the AES block sequencing controller.
package aes_package;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEYEXP,
        ST_WAIT_IN,
        ST_ROUND,
        ST_WAIT_OUT,
        ST_DONE
    } aes_sched_state_t;

    localparam logic [3:0] AES_NR_128 = 4'd10;
    localparam logic [3:0] AES_NR_192 = 4'd12;
    localparam logic [3:0] AES_NR_256 = 4'd14;

    localparam logic [1:0] AES_KEYLEN_128  = 2'b00;
    localparam logic [1:0] AES_KEYLEN_192  = 2'b01;
    localparam logic [1:0] AES_KEYLEN_256  = 2'b10;
    localparam logic [1:0] AES_KEYLEN_RSVD = 2'b11;

    typedef struct packed {
        logic       key_exp_start;
        logic       in_ready;
        logic       eng_load;
        logic       round_en;
        logic [3:0] round_idx;
        logic       last;
        logic       out_valid;
    } ctrl_sched_t;

    typedef struct packed {
        logic busy;
        logic done;
        logic err;
    } flags_sched_t;

    // Reserved length never reaches the round loop; any Nr is fine there.
    function automatic logic [3:0] aes_nr(input logic [1:0] key_len);
        logic [3:0] nr;
        case (key_len)
            AES_KEYLEN_128: nr = AES_NR_128;
            AES_KEYLEN_192: nr = AES_NR_192;
            AES_KEYLEN_256: nr = AES_NR_256;
            default:        nr = AES_NR_128;
        endcase
        return nr;
    endfunction

endpackage

// File: rtl/aes_block_sched.sv
// Job sequencer for the AES engine: key expansion trigger, per-block
// round schedule, result release and completion/error reporting.
module aes_block_sched
    import aes_package::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             test_mode_i,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] nb_blocks_i,
    input  logic [1:0]       key_len_i,
    output logic             key_exp_start_o,
    input  logic             key_exp_done_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             eng_load_o,
    output logic             eng_round_en_o,
    output logic [3:0]       eng_round_idx_o,
    output logic             eng_last_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] blk_cnt_o
);

    aes_sched_state_t state_q, state_d;
    logic [3:0]       rnd_q, rnd_d;
    logic [3:0]       nr_q, nr_d;
    logic [CNT_W-1:0] blk_q, blk_d;
    logic [CNT_W-1:0] nb_q, nb_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] blk_inc;
    ctrl_sched_t      ctrl;
    flags_sched_t     flags;
    logic             unused_test_mode;

    assign unused_test_mode = test_mode_i;
    assign blk_inc = blk_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            rnd_q   <= '0;
            nr_q    <= '0;
            blk_q   <= '0;
            nb_q    <= '0;
            err_q   <= 1'b0;
        end else if (clear_i) begin
            state_q <= ST_IDLE;
            rnd_q   <= '0;
            nr_q    <= '0;
            blk_q   <= '0;
            nb_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            nr_q    <= nr_d;
            blk_q   <= blk_d;
            nb_q    <= nb_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rnd_d      = rnd_q;
        nr_d       = nr_q;
        blk_d      = blk_q;
        nb_d       = nb_q;
        err_d      = err_q;
        ctrl       = '0;
        flags      = '0;
        flags.busy = (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    nb_d  = nb_blocks_i;
                    nr_d  = aes_nr(key_len_i);
                    rnd_d = '0;
                    blk_d = '0;
                    if (key_len_i == AES_KEYLEN_RSVD) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (nb_blocks_i == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        ctrl.key_exp_start = 1'b1;
                        state_d            = ST_KEYEXP;
                    end
                end
            end
            ST_KEYEXP: begin
                if (key_exp_done_i) state_d = ST_WAIT_IN;
            end
            ST_WAIT_IN: begin
                ctrl.in_ready = 1'b1;
                if (in_valid_i) begin
                    ctrl.eng_load = 1'b1;
                    rnd_d         = 4'd1;
                    state_d       = ST_ROUND;
                end
            end
            ST_ROUND: begin
                ctrl.round_en  = 1'b1;
                ctrl.round_idx = rnd_q;
                ctrl.last      = (rnd_q == nr_q);
                if (ctrl.last) state_d = ST_WAIT_OUT;
                else           rnd_d   = rnd_q + 4'd1;
            end
            ST_WAIT_OUT: begin
                ctrl.out_valid = 1'b1;
                if (out_ready_i) begin
                    blk_d   = blk_inc;
                    state_d = (blk_inc == nb_q) ? ST_DONE : ST_WAIT_IN;
                end
            end
            ST_DONE: begin
                flags.done = 1'b1;
                flags.err  = err_q;
                err_d      = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign key_exp_start_o = ctrl.key_exp_start;
    assign in_ready_o      = ctrl.in_ready;
    assign eng_load_o      = ctrl.eng_load;
    assign eng_round_en_o  = ctrl.round_en;
    assign eng_round_idx_o = ctrl.round_idx;
    assign eng_last_o      = ctrl.last;
    assign out_valid_o     = ctrl.out_valid;
    assign busy_o          = flags.busy;
    assign done_o          = flags.done;
    assign err_o           = flags.err;
    assign blk_cnt_o       = blk_q;

endmodule

// File: doc/aes_block_sched.md
# aes_block_sched

Sequencing controller for the AES engine of the HWPE accelerator. It sits between the control slave (job trigger and register-file parameters) and the engine/streamer handshakes. For one job it:
- triggers key expansion once;
- runs the full round schedule for each 128-bit block;
- releases each result block to the output stream;
- reports completion.

## Interface
Parameters:
- CNT_W, 16, width of the block counter and of nb_blocks_i.

Ports (clk and reset first):
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock, reset is asynchronous and active-low.
- test_mode_i  in  1  test mode; no functional effect.
- clear_i  in  1  synchronous soft clear. Same effect as reset, highest priority.
- start_i  in  1  job trigger pulse. Ignored unless the FSM is in IDLE.
- nb_blocks_i  in  CNT_W  number of blocks in the job. Sampled on an accepted start.
- key_len_i  in  2  key length, sampled on an accepted start: 00 = AES-128 (Nr=10), 01 = AES-192 (Nr=12), 10 = AES-256 (Nr=14), 11 = reserved.
- key_exp_start_o  out  1  one-cycle pulse to the key expander.
- key_exp_done_i  in  1  key expansion complete (level or pulse).
- in_valid_i / in_ready_o  in/out  1  input block handshake from the streamer.
- eng_load_o  out  1  load input block and apply round-key 0.
- eng_round_en_o  out  1  execute one round.
- eng_round_idx_o  out  4  current round index, 1..Nr. Value 0 when idle.
- eng_last_o  out  1  final round (engine skips MixColumns).
- out_valid_o / out_ready_i  out/in  1  result block handshake to the streamer.
- busy_o  out  1  FSM is not in IDLE.
- done_o  out  1  one-cycle job-complete pulse.
- err_o  out  1  pulses together with done_o when key_len was 11.
- blk_cnt_o  out  CNT_W  number of blocks completed in the current job.

## Operation
FSM states: IDLE, KEYEXP, WAIT_IN, ROUND, WAIT_OUT, DONE.

- **IDLE**
  - On start_i, latch nb_blocks_i and Nr. Clear the round and block counters.
  - If key_len_i==11: set the error flag and go to DONE.
  - Else if nb_blocks_i==0: go to DONE. No key expansion, err 0.
  - Else: pulse key_exp_start_o in the same cycle and go to KEYEXP.
- **KEYEXP**: wait for key_exp_done_i, then go to WAIT_IN. key_exp_done_i is not sampled in IDLE.
- **WAIT_IN**
  - in_ready_o=1.
  - On in_valid_i: assert eng_load_o (combinational), set round counter to 1, go to ROUND.
- **ROUND**
  - eng_round_en_o=1; eng_round_idx_o = round counter.
  - eng_last_o = (round counter == Nr).
  - When last, go to WAIT_OUT. Otherwise increment the round counter.
  - The engine is fixed-latency; there is no stall input.
- **WAIT_OUT**
  - out_valid_o=1; it stays high until out_ready_i.
  - On out_ready_i, increment blk_cnt. If the new count equals the latched nb_blocks, go to DONE; otherwise go to WAIT_IN.
- **DONE**: done_o=1, err_o = error flag. Next state is IDLE; the error flag clears.

Further rules:
- start_i outside IDLE is dropped. It is neither queued nor re-latched.
- Changes to nb_blocks_i or key_len_i mid-job have no effect.
- blk_cnt_o holds its final value in IDLE until the next accepted start.
- Counters never wrap: nb_blocks = 2^CNT_W − 1 completes normally.
- Reset or clear mid-job returns to IDLE immediately. No done_o is produced and all outputs go to reset values.

## Timing
- Reset value of every output: 0. Hence eng_round_idx_o=0 and blk_cnt_o=0.
- All state, counters and latched config are registered.
- Outputs:
  - Moore-decoded from state: in_ready_o, out_valid_o, round controls, busy_o, done_o.
  - Mealy: eng_load_o and key_exp_start_o (same cycle as the accepting handshake or start).
- Per block with zero-wait handshakes: 1 load cycle + Nr round cycles + 1 output cycle = Nr+2 cycles.
- Block throughput is the same; there is no overlap between blocks.
- done_o is asserted 1 cycle after the last out_ready_i handshake.
- Start-to-done for nb=0 or reserved key: 1 cycle (DONE in cycle t+1).

## Structure
- aes_package holds:
  - typedef aes_sched_state_t (enum);
  - constants AES_NR_128/192/256 = 10/12/14;
  - AES_KEYLEN_* encodings;
  - ctrl_sched_t / flags_sched_t structs, so the FSM can later bundle these ports.
- Nr decoding is a function in aes_package.
- No sub-modules: single FSM plus two counters.

## Test plan
- AES-128, nb=1, all handshakes immediate, start at cycle 0, key_exp_done_i at cycle 1:
  - in_ready_o at cycle 2 with eng_load_o;
  - round idx 1..10 at cycles 3..12, eng_last_o only at 12;
  - out_valid_o at 13; done_o at 14; busy_o low at 15.
- AES-256, nb=3, out_ready_i held low 5 cycles on block 2:
  - 14 round pulses per block, last at idx 14;
  - out_valid_o held for 6 cycles;
  - blk_cnt_o steps 1,2,3;
  - exactly one done_o, err_o=0.
- nb=0 and key_len=11:
  - done_o 1 cycle after start; key_exp_start_o never asserted;
  - err_o=1 only for key_len=11;
  - no in_ready_o.
- start_i re-pulsed during ROUND with a different nb:
  - ignored; the job finishes with the original count;
  - a single done_o.
- rst_ni low (and separately clear_i high) during ROUND idx 5:
  - all outputs 0 next edge, no done_o;
  - a new start then runs the full nominal sequence.
- AES-192, nb=2, in_valid_i delayed 4 cycles per block:
  - in_ready_o stays high while waiting; eng_load_o only on the handshake cycle;
  - 12 rounds per block.
